// File: rtl/mips_mem_pkg.sv
// Shared types and decode helpers for the wait-state MIPS MEM stage.
// Little-endian byte lanes; sizes are decoded with Byte taking priority over Half.
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, SWEEP} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  function automatic size_e decode_size(input logic byte_sel, input logic half_sel);
    if (byte_sel) return SZ_BYTE;
    if (half_sel) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

  function automatic logic [3:0] byte_mask(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Right-aligned store data is replicated so every candidate lane carries it.
  function automatic logic [31:0] place_store(input size_e size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input size_e size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_stage_ws_ram.sv
// Single-port data RAM: byte-enable write, registered read issued only when
// enabled without any write lane, so the read register holds between loads.
module mips_mem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  // NOTE: the array has no reset; its contents are meant to survive CLR and a
  // reset loop over every word would stop it mapping onto a block RAM.
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
      if (i_we == 4'b0000) r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_mem_stage_ws.sv
// MEM stage with configurable wait states, stall, registered MEM/WB result and
// misalignment detection. Optional macro MEM_CLEAR_SWEEP_EN zeroes the RAM after CLR.
module mips_mem_stage_ws
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] R1_in,
  input  logic [31:0]       data_in,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              UnsignedExt_Mem,
  input  logic              Byte,
  input  logic              Half,
  output logic              stall,
  output logic              R1_valid,
  output logic [31:0]       R1,
  output logic              misalign
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  req_t        r_req, w_in_req, w_acc_req;
  logic        w_accept, w_complete, w_use_latched, w_acc_mem, w_mis;

  logic        r_valid, r_mis, r_from_mem, r_res_uns;
  logic [31:0] r_r1;
  size_e       r_res_size;
  logic [1:0]  r_res_lane;

  logic          w_ram_en;
  logic [3:0]    w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [31:0]   w_ram_wdata, w_rdata;

`ifdef MEM_CLEAR_SWEEP_EN
  logic [AW-1:0] r_sweep_idx;
`endif

  assign stall    = (r_state == WAIT) || (r_state == SWEEP);
  assign w_accept = req_valid && !stall && !CLR;

  always_comb begin
    w_in_req.is_load  = MemtoReg;
    w_in_req.is_store = MemWrite && !MemtoReg;
    w_in_req.size     = decode_size(Byte, Half);
    w_in_req.uns      = UnsignedExt_Mem;
    w_in_req.addr     = 32'(R1_in);
    w_in_req.data     = data_in;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_complete    = 1'b0;
    w_use_latched = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (w_accept) begin
          if (!(w_in_req.is_load || w_in_req.is_store) || (WAIT_STATES == 0)) begin
            w_complete = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WS;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_complete    = 1'b1;
          w_use_latched = 1'b1;
          w_state_nxt   = DONE;
        end
      end
      SWEEP: begin
`ifdef MEM_CLEAR_SWEEP_EN
        if (r_sweep_idx == AW'(DEPTH_WORDS - 1)) w_state_nxt = IDLE;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Single-cycle accesses come straight from the inputs; waited ones from the latch.
  assign w_acc_req = w_use_latched ? r_req : w_in_req;
  assign w_acc_mem = w_acc_req.is_load || w_acc_req.is_store;
  assign w_mis     = w_acc_mem && is_misaligned(w_acc_req.size, w_acc_req.addr[1:0]);

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 4'b0000;
    w_ram_addr  = w_acc_req.addr[2 +: AW];
    w_ram_wdata = place_store(w_acc_req.size, w_acc_req.data);
    if (!CLR && w_complete && w_acc_mem && !w_mis) begin
      w_ram_en = 1'b1;
      if (w_acc_req.is_store) w_ram_we = byte_mask(w_acc_req.size, w_acc_req.addr[1:0]);
    end
`ifdef MEM_CLEAR_SWEEP_EN
    if (!CLR && (r_state == SWEEP)) begin
      w_ram_en    = 1'b1;
      w_ram_we    = 4'b1111;
      w_ram_addr  = r_sweep_idx;
      w_ram_wdata = 32'h0;
    end
`endif
  end

  mips_mem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_rdata)
  );

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (CLR) begin
`ifdef MEM_CLEAR_SWEEP_EN
      r_state     <= SWEEP;
      r_sweep_idx <= '0;
`else
      r_state     <= IDLE;
`endif
      r_cnt      <= 3'd0;
      r_valid    <= 1'b0;
      r_mis      <= 1'b0;
      r_r1       <= 32'h0;
      r_from_mem <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_complete;
      r_mis   <= w_complete && w_mis;
      if (w_accept) r_req <= w_in_req;
      if (w_complete) begin
        r_from_mem <= w_acc_req.is_load && !w_mis;
        r_r1       <= w_mis ? 32'h0 : w_acc_req.addr;
        r_res_size <= w_acc_req.size;
        r_res_lane <= w_acc_req.addr[1:0];
        r_res_uns  <= w_acc_req.uns;
      end
`ifdef MEM_CLEAR_SWEEP_EN
      if (r_state == SWEEP) r_sweep_idx <= r_sweep_idx + AW'(1);
`endif
    end
  end

  // Load results are formed from the RAM read register, which only changes on a read.
  assign R1       = r_from_mem ? extract_load(w_rdata, r_res_size, r_res_lane, r_res_uns) : r_r1;
  assign R1_valid = r_valid;
  assign misalign = r_mis;

endmodule

// File: tb/tb_mips_mem_stage_ws.sv
// Self-checking bench: three stage instances (0, 3 and 2 wait states) checked
// every cycle against a byte-array transaction model plus literal expectations.
module tb_mips_mem_stage_ws;

  localparam int ND = 3;

  typedef enum {OP_LD, OP_ST, OP_PASS, OP_BOTH} op_e;
  typedef enum {SZW, SZH, SZB} sz_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr [ND];
  logic        req_valid [ND];
  logic [31:0] r1_in [ND];
  logic [31:0] data_in [ND];
  logic        mem_write [ND];
  logic        mem_to_reg [ND];
  logic        uns_ext [ND];
  logic        byte_s [ND];
  logic        half_s [ND];
  logic        stall [ND];
  logic        r1_valid [ND];
  logic [31:0] r1 [ND];
  logic        misalign [ND];

  mips_mem_stage_ws #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .CLR(clr[0]), .req_valid(req_valid[0]), .R1_in(r1_in[0]), .data_in(data_in[0]),
    .MemWrite(mem_write[0]), .MemtoReg(mem_to_reg[0]), .UnsignedExt_Mem(uns_ext[0]),
    .Byte(byte_s[0]), .Half(half_s[0]), .stall(stall[0]), .R1_valid(r1_valid[0]),
    .R1(r1[0]), .misalign(misalign[0]));

  mips_mem_stage_ws #(.DEPTH_WORDS(16), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .CLR(clr[1]), .req_valid(req_valid[1]), .R1_in(r1_in[1]), .data_in(data_in[1]),
    .MemWrite(mem_write[1]), .MemtoReg(mem_to_reg[1]), .UnsignedExt_Mem(uns_ext[1]),
    .Byte(byte_s[1]), .Half(half_s[1]), .stall(stall[1]), .R1_valid(r1_valid[1]),
    .R1(r1[1]), .misalign(misalign[1]));

  mips_mem_stage_ws #(.DEPTH_WORDS(8), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .CLR(clr[2]), .req_valid(req_valid[2]), .R1_in(r1_in[2]), .data_in(data_in[2]),
    .MemWrite(mem_write[2]), .MemtoReg(mem_to_reg[2]), .UnsignedExt_Mem(uns_ext[2]),
    .Byte(byte_s[2]), .Half(half_s[2]), .stall(stall[2]), .R1_valid(r1_valid[2]),
    .R1(r1[2]), .misalign(misalign[2]));

  function automatic int dep_of(input int d);
    return (d == 2) ? 8 : 16;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  logic [7:0]  mem_m [ND][64];
  bit          m_busy [ND];
  int          m_left [ND];
  int          m_sweep [ND];
  logic        p_mw [ND], p_mtr [ND], p_uns [ND], p_by [ND], p_hf [ND];
  logic [31:0] p_addr [ND], p_data [ND];
  logic [31:0] e_r1 [ND];
  logic        e_stall [ND], e_valid [ND], e_mis [ND];

  task automatic finish_op(input int d);
    int          nb, base;
    logic [31:0] v;
    bit          mis;
    nb   = p_by[d] ? 1 : (p_hf[d] ? 2 : 4);
    base = int'(p_addr[d] % 32'(4 * dep_of(d)));
    mis  = (p_mw[d] || p_mtr[d]) &&
           (((nb == 2) && p_addr[d][0]) || ((nb == 4) && (p_addr[d][1:0] != 2'b00)));
    e_valid[d] = 1'b1;
    e_mis[d]   = mis;
    if (!p_mw[d] && !p_mtr[d]) e_r1[d] = p_addr[d];
    else if (mis) e_r1[d] = 32'h0;
    else if (p_mtr[d]) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_m[d][base + i]) << (8 * i));
      if (!p_uns[d] && (nb < 4) && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      e_r1[d] = v;
    end else begin
      for (int i = 0; i < nb; i++) mem_m[d][base + i] = p_data[d][8 * i +: 8];
      e_r1[d] = p_addr[d];
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      e_valid[d] = 1'b0;
      e_mis[d]   = 1'b0;
      if (clr[d]) begin
        m_busy[d] = 1'b0;
        e_r1[d]   = 32'h0;
`ifdef MEM_CLEAR_SWEEP_EN
        m_sweep[d] = dep_of(d);
        for (int i = 0; i < 64; i++) mem_m[d][i] = 8'h00;
`endif
      end else if (m_sweep[d] > 0) begin
        m_sweep[d]--;
      end else if (m_busy[d]) begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_busy[d] = 1'b0;
          finish_op(d);
        end
      end else if (req_valid[d]) begin
        p_mw[d] = mem_write[d]; p_mtr[d] = mem_to_reg[d]; p_uns[d] = uns_ext[d];
        p_by[d] = byte_s[d]; p_hf[d] = half_s[d]; p_addr[d] = r1_in[d]; p_data[d] = data_in[d];
        if ((!p_mw[d] && !p_mtr[d]) || (ws_of(d) == 0)) finish_op(d);
        else begin
          m_busy[d] = 1'b1;
          m_left[d] = ws_of(d);
        end
      end
      e_stall[d] = m_busy[d] || (m_sweep[d] > 0);
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("d%0d_stall", d), 32'(stall[d]), 32'(e_stall[d]));
        check($sformatf("d%0d_valid", d), 32'(r1_valid[d]), 32'(e_valid[d]));
        check($sformatf("d%0d_r1", d), r1[d], e_r1[d]);
        check($sformatf("d%0d_misalign", d), 32'(misalign[d]), 32'(e_mis[d]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int d, input op_e op, input sz_e sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] data);
    r1_in[d]      = addr;
    data_in[d]    = data;
    mem_write[d]  = (op == OP_ST) || (op == OP_BOTH);
    mem_to_reg[d] = (op == OP_LD) || (op == OP_BOTH);
    uns_ext[d]    = uns;
    byte_s[d]     = (sz == SZB);
    half_s[d]     = (sz == SZH);
  endtask

  task automatic wait_ready(input int d);
    int guard = 0;
    while (stall[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_err++;
      $display("FAIL d%0d_ready_timeout: stall still high after %0d cycles", d, guard);
    end
  endtask

  // Presents one request, optionally scrambles inputs while stalled, returns at the
  // negedge of the completion cycle and checks the literal result and stall count.
  task automatic do_op(input int d, input string name, input op_e op, input sz_e sz,
                       input bit uns, input logic [31:0] addr, input logic [31:0] data,
                       input bit scramble, input logic [31:0] exp_r1, input bit exp_mis,
                       input int exp_stalls);
    int stalls = 0;
    wait_ready(d);
    drive(d, op, sz, uns, addr, data);
    req_valid[d] = 1'b1;
    @(negedge clk);
    if (!scramble) req_valid[d] = 1'b0;
    while (stall[d] && stalls < 100) begin
      if (scramble) begin
        r1_in[d]      = $urandom;
        data_in[d]    = $urandom;
        mem_write[d]  = 1'($urandom_range(1));
        mem_to_reg[d] = 1'($urandom_range(1));
        uns_ext[d]    = 1'($urandom_range(1));
        byte_s[d]     = 1'($urandom_range(1));
        half_s[d]     = 1'($urandom_range(1));
      end
      @(negedge clk);
      stalls++;
    end
    req_valid[d] = 1'b0;
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    check({name, "_valid"}, 32'(r1_valid[d]), 32'd1);
    check({name, "_r1"}, r1[d], exp_r1);
    check({name, "_misalign"}, 32'(misalign[d]), 32'(exp_mis));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] old_word;
    for (int d = 0; d < ND; d++) begin
      clr[d] = 1'b1;
      req_valid[d] = 1'b0;
      drive(d, OP_PASS, SZW, 1'b0, 32'h0, 32'h0);
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) clr[d] = 1'b0;
    chk_en = 1'b1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d_reset_r1", d), r1[d], 32'h0);
      check($sformatf("d%0d_reset_valid", d), 32'(r1_valid[d]), 32'd0);
    end

    // Zero wait states: single-cycle accesses, byte/half extension, lane stores.
    do_op(0, "st_word",   OP_ST,   SZW, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h10, 1'b0, 0);
    do_op(0, "ld_word",   OP_LD,   SZW, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);
    do_op(0, "ld_b_sign", OP_LD,   SZB, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFDE, 1'b0, 0);
    do_op(0, "ld_b_uns",  OP_LD,   SZB, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_00DE, 1'b0, 0);
    do_op(0, "ld_h_sign", OP_LD,   SZH, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_DEAD, 1'b0, 0);
    do_op(0, "st_byte",   OP_ST,   SZB, 1'b0, 32'h11, 32'hAAAA_AA55, 1'b0, 32'h11, 1'b0, 0);
    do_op(0, "ld_after_b",OP_LD,   SZW, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_55EF, 1'b0, 0);
    do_op(0, "both_is_ld",OP_BOTH, SZW, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_55EF, 1'b0, 0);
    do_op(0, "no_store",  OP_LD,   SZW, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_55EF, 1'b0, 0);
    do_op(0, "pass",      OP_PASS, SZW, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 0);
    do_op(0, "st_alias",  OP_ST,   SZW, 1'b0, 32'd68, 32'hCAFE_F00D, 1'b0, 32'd68, 1'b0, 0);
    do_op(0, "ld_alias",  OP_LD,   SZW, 1'b0, 32'h4, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 0);
    do_op(0, "st_0x20",   OP_ST,   SZW, 1'b0, 32'h20, 32'h0BAD_F00D, 1'b0, 32'h20, 1'b0, 0);
    do_op(0, "mis_st_h",  OP_ST,   SZH, 1'b0, 32'h21, 32'h0000_FFFF, 1'b0, 32'h0, 1'b1, 0);
    do_op(0, "mis_st_w",  OP_ST,   SZW, 1'b0, 32'h22, 32'h1111_2222, 1'b0, 32'h0, 1'b1, 0);
    do_op(0, "mis_ld_h",  OP_LD,   SZH, 1'b0, 32'h21, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    do_op(0, "unchanged", OP_LD,   SZW, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("hold_r1", r1[0], 32'h0BAD_F00D);

    // Three wait states with inputs scrambled while stalled.
    do_op(1, "ws3_st",    OP_ST,   SZW, 1'b0, 32'h10, 32'hA5A5_A5A5, 1'b1, 32'h10, 1'b0, 3);
    do_op(1, "ws3_ld",    OP_LD,   SZW, 1'b0, 32'h10, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b0, 3);
    do_op(1, "ws3_ld_hu", OP_LD,   SZH, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000_A5A5, 1'b0, 3);
    do_op(1, "ws3_mis",   OP_LD,   SZW, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0, 1'b1, 3);
    do_op(1, "ws3_pass",  OP_PASS, SZW, 1'b0, 32'h0000_BEEF, 32'h0, 1'b0, 32'h0000_BEEF, 1'b0, 0);

    // Two wait states: a store aborted by CLR in its first wait cycle.
    do_op(2, "ws2_st_old", OP_ST, SZW, 1'b0, 32'h8, 32'h1111_1111, 1'b0, 32'h8, 1'b0, 2);
    wait_ready(2);
    drive(2, OP_ST, SZW, 1'b0, 32'h8, 32'h2222_2222);
    req_valid[2] = 1'b1;
    @(negedge clk);
    check("abort_stall", 32'(stall[2]), 32'd1);
    req_valid[2] = 1'b0;
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
`ifdef MEM_CLEAR_SWEEP_EN
    n = 0;
    while (stall[2] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sweep_stall_cycles", 32'(n), 32'd8);
    for (int w = 0; w < 8; w++)
      do_op(2, $sformatf("sweep_zero%0d", w), OP_LD, SZW, 1'b0, 32'(4 * w), 32'h0, 1'b0,
            32'h0, 1'b0, 2);
    old_word = 32'h0;
`else
    n = 0;
    check("abort_no_stall", 32'(stall[2]), 32'd0);
    old_word = 32'h1111_1111;
`endif
    repeat (3) @(negedge clk);
    do_op(2, "abort_old", OP_LD, SZW, 1'b0, 32'h8, 32'h0, 1'b0, old_word, 1'b0, 2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
